// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: credits nickel/dime/quarter pulses, vends at PRICE,
// then pays change (greedy 25/10/5) one coin per hopper handshake. Cancel refunds credit.
module vend_ctrl #(
    parameter int unsigned PRICE    = 35,
    parameter int unsigned CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                n_i,
    input  logic                d_i,
    input  logic                q_i,
    input  logic                cancel_i,
    input  logic                chg_ready_i,
    output logic                vend_o,
    output logic                chg_valid_o,
    output logic [1:0]          chg_coin_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o,
    output logic                coin_reject_o
);

    generate
        if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > (2 ** CREDIT_W) - 26) begin : g_bad_price
            $error("vend_ctrl: PRICE must be a multiple of 5 in 5..2**CREDIT_W-26");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] C25     = CREDIT_W'(25);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  reject_q, reject_d;

    logic                  multi_coin, one_coin, any_coin;
    logic [CREDIT_W-1:0]   coin_val;
    logic [1:0]            chg_code;
    logic [CREDIT_W-1:0]   chg_val;

    assign any_coin   = n_i | d_i | q_i;
    assign multi_coin = (n_i & d_i) | (n_i & q_i) | (d_i & q_i);
    assign one_coin   = any_coin & ~multi_coin;

    always_comb begin
        coin_val = '0;
        if (n_i)      coin_val = C5;
        else if (d_i) coin_val = C10;
        else if (q_i) coin_val = C25;
    end

    // Greedy change selection; credit is always a multiple of 5 so it lands on 0 exactly.
    always_comb begin
        if (credit_q >= C25) begin
            chg_code = 2'b11;
            chg_val  = C25;
        end else if (credit_q >= C10) begin
            chg_code = 2'b10;
            chg_val  = C10;
        end else begin
            chg_code = 2'b01;
            chg_val  = C5;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_COLLECT;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = multi_coin | (any_coin & ((state_q != S_COLLECT) | cancel_i));
        unique case (state_q)
            S_COLLECT: begin
                // A coin arriving with cancel is bounced; an empty cancel has nothing to refund.
                if (cancel_i) begin
                    if (credit_q != '0) state_d = S_CHANGE;
                end else if (one_coin) begin
                    credit_d = credit_q + coin_val;
                    if (credit_d >= PRICE_C) state_d = S_VEND;
                end
            end
            S_VEND: begin
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_d != '0) ? S_CHANGE : S_COLLECT;
            end
            S_CHANGE: begin
                if (chg_ready_i) begin
                    credit_d = credit_q - chg_val;
                    if (credit_d == '0) state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        vend_o        = (state_q == S_VEND);
        chg_valid_o   = (state_q == S_CHANGE);
        chg_coin_o    = (state_q == S_CHANGE) ? chg_code : 2'b00;
        credit_o      = credit_q;
        busy_o        = (state_q != S_COLLECT);
        coin_reject_o = reject_q;
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: PRICE=35 and PRICE=60 instances, scoreboard of vend/change events.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       n[2], d[2], q[2], cancel[2], chg_ready[2];
    logic       vend[2], chg_valid[2], busy[2], coin_reject[2];
    logic [1:0] coin[2];
    logic [7:0] credit[2];

    typedef struct {
        bit         is_vend;
        logic [1:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  nvec  = 0;
    int  nfail = 0;
    int  sel   = 0;

    always #5 clk = ~clk;

    vend_ctrl #(.PRICE(35), .CREDIT_W(8)) u_p35 (
        .clk(clk), .rst_n(rst_n),
        .n_i(n[0]), .d_i(d[0]), .q_i(q[0]), .cancel_i(cancel[0]), .chg_ready_i(chg_ready[0]),
        .vend_o(vend[0]), .chg_valid_o(chg_valid[0]), .chg_coin_o(coin[0]),
        .credit_o(credit[0]), .busy_o(busy[0]), .coin_reject_o(coin_reject[0])
    );

    vend_ctrl #(.PRICE(60), .CREDIT_W(8)) u_p60 (
        .clk(clk), .rst_n(rst_n),
        .n_i(n[1]), .d_i(d[1]), .q_i(q[1]), .cancel_i(cancel[1]), .chg_ready_i(chg_ready[1]),
        .vend_o(vend[1]), .chg_valid_o(chg_valid[1]), .chg_coin_o(coin[1]),
        .credit_o(credit[1]), .busy_o(busy[1]), .coin_reject_o(coin_reject[1])
    );

    function automatic void exp_vend();
        ev_t e;
        e.is_vend = 1'b1;
        e.code    = 2'b00;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_coin(input logic [1:0] code);
        ev_t e;
        e.is_vend = 1'b0;
        e.code    = code;
        exp_q.push_back(e);
    endfunction

    // Observe the selected DUT mid-cycle, pop the scoreboard on vend/handshake, advance one clock.
    task automatic tick();
        ev_t e;
        if (vend[sel]) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL vend_event: got unexpected vend, required none");
            end else begin
                e = exp_q.pop_front();
                if (!e.is_vend) begin
                    nfail++;
                    $display("FAIL vend_event: got vend, required coin %b", e.code);
                end
            end
        end
        if (chg_valid[sel] && chg_ready[sel]) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL change_event: got unexpected coin %b, required none", coin[sel]);
            end else begin
                e = exp_q.pop_front();
                if (e.is_vend || coin[sel] !== e.code) begin
                    nfail++;
                    $display("FAIL change_event: got coin %b, required %s %b", coin[sel],
                             e.is_vend ? "vend" : "coin", e.code);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic insert(input bit nn, input bit dd, input bit qq);
        n[sel] = nn; d[sel] = dd; q[sel] = qq;
        tick();
        n[sel] = 1'b0; d[sel] = 1'b0; q[sel] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        nvec++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL %s_drain: %0d events still pending, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        nvec++;
        if (credit[sel] !== 8'd0 || busy[sel] !== 1'b0) begin
            nfail++;
            $display("FAIL %s_idle: credit=%0d busy=%b, required credit=0 busy=0", tag,
                     credit[sel], busy[sel]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if ({vend[i], chg_valid[i], busy[i], coin_reject[i], coin[i], credit[i]} !== 14'd0) begin
                nfail++;
                $display("FAIL reset_dut%0d: vend=%b valid=%b busy=%b rej=%b coin=%b credit=%0d, required all 0",
                         i, vend[i], chg_valid[i], busy[i], coin_reject[i], coin[i], credit[i]);
            end
        end
    endtask

    task automatic test_exact();
        sel = 0;
        for (int k = 0; k < 2; k++) begin
            // k=0: D then Q, k=1: Q then D; both total exactly 35
            if (k == 0) insert(0, 1, 0); else insert(0, 0, 1);
            nvec++;
            if (credit[0] !== (k == 0 ? 8'd10 : 8'd25) || coin_reject[0] !== 1'b0) begin
                nfail++;
                $display("FAIL exact_first_coin: credit=%0d rej=%b, required credit=%0d rej=0",
                         credit[0], coin_reject[0], (k == 0 ? 10 : 25));
            end
            exp_vend();
            if (k == 0) insert(0, 0, 1); else insert(0, 1, 0);
            nvec++;
            if (credit[0] !== 8'd35 || busy[0] !== 1'b1 || chg_valid[0] !== 1'b0) begin
                nfail++;
                $display("FAIL exact_vend_cycle: credit=%0d busy=%b valid=%b, required 35 1 0",
                         credit[0], busy[0], chg_valid[0]);
            end
            wait_drain("exact");
            nvec++;
            if (vend[0] !== 1'b0 || chg_valid[0] !== 1'b0) begin
                nfail++;
                $display("FAIL exact_after: vend=%b valid=%b, required 0 0", vend[0], chg_valid[0]);
            end
        end
    endtask

    task automatic test_change_50();
        sel = 0;
        insert(1, 0, 0); insert(0, 1, 0); insert(1, 0, 0); insert(1, 0, 0);
        nvec++;
        if (credit[0] !== 8'd25) begin
            nfail++;
            $display("FAIL change50_credit: got %0d, required 25", credit[0]);
        end
        exp_vend(); exp_coin(2'b10); exp_coin(2'b01);
        insert(0, 0, 1);
        wait_drain("change50");
    endtask

    task automatic test_stall();
        sel = 0;
        chg_ready[0] = 1'b0;
        exp_vend(); exp_coin(2'b10); exp_coin(2'b10);
        insert(0, 0, 1); insert(1, 0, 0); insert(0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (chg_valid[0] !== 1'b1 || coin[0] !== 2'b10 || credit[0] !== 8'd20) begin
                nfail++;
                $display("FAIL stall_hold%0d: valid=%b coin=%b credit=%0d, required 1 10 20",
                         i, chg_valid[0], coin[0], credit[0]);
            end
            tick();
        end
        chg_ready[0] = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_price60();
        sel = 1;
        exp_vend(); exp_coin(2'b10); exp_coin(2'b01);
        insert(0, 0, 1); insert(0, 0, 1);
        nvec++;
        if (credit[1] !== 8'd50 || busy[1] !== 1'b0) begin
            nfail++;
            $display("FAIL p60_credit: credit=%0d busy=%b, required 50 0", credit[1], busy[1]);
        end
        insert(0, 0, 1);
        wait_drain("p60");
        sel = 0;
    endtask

    task automatic test_cancel();
        sel = 0;
        insert(0, 0, 1); insert(1, 0, 0);
        exp_coin(2'b11); exp_coin(2'b01);
        cancel[0] = 1'b1;
        tick();
        cancel[0] = 1'b0;
        nvec++;
        if (busy[0] !== 1'b1 || credit[0] !== 8'd30 || coin[0] !== 2'b11) begin
            nfail++;
            $display("FAIL cancel_refund: busy=%b credit=%0d coin=%b, required 1 30 11",
                     busy[0], credit[0], coin[0]);
        end
        wait_drain("cancel");
        cancel[0] = 1'b1;
        tick();
        cancel[0] = 1'b0;
        nvec++;
        if (busy[0] !== 1'b0 || chg_valid[0] !== 1'b0 || credit[0] !== 8'd0) begin
            nfail++;
            $display("FAIL cancel_empty: busy=%b valid=%b credit=%0d, required 0 0 0",
                     busy[0], chg_valid[0], credit[0]);
        end
        tick(); tick();
    endtask

    task automatic test_reject_reset();
        sel = 0;
        insert(1, 0, 0);
        insert(1, 1, 0);
        nvec++;
        if (coin_reject[0] !== 1'b1 || credit[0] !== 8'd5) begin
            nfail++;
            $display("FAIL multi_coin: rej=%b credit=%0d, required 1 5", coin_reject[0], credit[0]);
        end
        tick();
        nvec++;
        if (coin_reject[0] !== 1'b0) begin
            nfail++;
            $display("FAIL reject_pulse: rej=%b, required 0", coin_reject[0]);
        end
        chg_ready[0] = 1'b0;
        exp_vend(); exp_coin(2'b01);
        insert(0, 0, 1); insert(0, 1, 0);
        tick();
        insert(1, 0, 0);
        nvec++;
        if (coin_reject[0] !== 1'b1 || credit[0] !== 8'd5 || coin[0] !== 2'b01) begin
            nfail++;
            $display("FAIL busy_coin: rej=%b credit=%0d coin=%b, required 1 5 01",
                     coin_reject[0], credit[0], coin[0]);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nvec++;
        if (credit[0] !== 8'd0 || chg_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mid_change: credit=%0d valid=%b busy=%b, required 0 0 0",
                     credit[0], chg_valid[0], busy[0]);
        end
        // The pending 5c coin is discarded by reset.
        nvec++;
        if (exp_q.size() != 1) begin
            nfail++;
            $display("FAIL reset_pending: %0d events pending, required 1", exp_q.size());
        end
        exp_q.delete();
        chg_ready[0] = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            n[i] = 1'b0; d[i] = 1'b0; q[i] = 1'b0; cancel[i] = 1'b0; chg_ready[i] = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        tick(); tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_exact();
        test_change_50();
        test_stall();
        test_price60();
        test_cancel();
        test_reject_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
